slc3_datapath_gen: RTL and testbench

Parametrised second-generation SLC-3 datapath: register file, ALU, NZP condition codes, BEN, PC/IR/MAR/MDR/LED registers and a single shared bus, plus an internal memory sequencer with req/ack handshake and timeout. It sits between the SLC-3 control FSM, which drives the load/gate/select strobes, and the memory/IO subsystem. Compared with the first-generation datapath, it adds width generality, a built-in ALU/CC/BEN path, bus-contention detection and a self-timed memory access.

---
 rtl/slc3_datapath_gen_pkg.sv | 34 +++
 rtl/slc3_datapath_gen_if.sv | 37 +++
 rtl/slc3_datapath_gen_mem_seq.sv | 80 ++++++++
 rtl/slc3_datapath_gen.sv | 151 +++++++++++++++
 tb/tb_slc3_datapath_gen.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_datapath_gen_pkg.sv
// Shared types for the SLC-3 datapath: mux/ALU encodings, memory sequencer states
// and the condition-code reset value.
package slc3_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_NOT  = 2'd2,
    ALU_PASS = 2'd3
  } aluk_e;

  typedef enum logic [1:0] {
    PC_INC  = 2'd0,
    PC_ADDR = 2'd1,
    PC_BUS  = 2'd2,
    PC_HOLD = 2'd3
  } pcmux_e;

  typedef enum logic [1:0] {
    A2_SEXT11 = 2'd0,
    A2_SEXT9  = 2'd1,
    A2_SEXT6  = 2'd2,
    A2_ZERO   = 2'd3
  } addr2_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memseq_state_e;

  localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/slc3_datapath_gen_if.sv
// Control-strobe, memory-handshake and architectural-register bundle between the
// SLC-3 control side (ctrl) and the datapath (dp).
interface slc3_datapath_gen_if #(
  parameter int DATA_W = 16,
  parameter int LED_W  = 12
);
  logic              ld_reg, ld_ben, ld_cc, ld_ir, ld_pc, ld_mar, ld_mdr, ld_led;
  logic              gate_marmux, gate_pc, gate_alu, gate_mdr;
  logic              dr_sel, sr1_sel, sr2_sel, addr1_sel, mio_en;
  logic [1:0]        addr2_sel, pc_sel, aluk;
  logic              mem_start, mem_we;
  logic              mem_req, mem_we_o;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              mem_ack;
  logic              busy, done, mem_err, bus_err, ben;
  logic [2:0]        nzp;
  logic [DATA_W-1:0] ir, pc, mar, mdr;
  logic [LED_W-1:0]  led;

  modport ctrl (
    output ld_reg, ld_ben, ld_cc, ld_ir, ld_pc, ld_mar, ld_mdr, ld_led,
    output gate_marmux, gate_pc, gate_alu, gate_mdr,
    output dr_sel, sr1_sel, sr2_sel, addr1_sel, mio_en, addr2_sel, pc_sel, aluk,
    output mem_start, mem_we, mem_rdata, mem_ack,
    input  mem_req, mem_we_o, mem_addr, mem_wdata,
    input  busy, done, mem_err, bus_err, ben, nzp, ir, pc, mar, mdr, led
  );

  modport dp (
    input  ld_reg, ld_ben, ld_cc, ld_ir, ld_pc, ld_mar, ld_mdr, ld_led,
    input  gate_marmux, gate_pc, gate_alu, gate_mdr,
    input  dr_sel, sr1_sel, sr2_sel, addr1_sel, mio_en, addr2_sel, pc_sel, aluk,
    input  mem_start, mem_we, mem_rdata, mem_ack,
    output mem_req, mem_we_o, mem_addr, mem_wdata,
    output busy, done, mem_err, bus_err, ben, nzp, ir, pc, mar, mdr, led
  );
endinterface

// File: rtl/slc3_datapath_gen_mem_seq.sv
// Memory access sequencer: IDLE (waiting for start) | REQ (request held, counting
// toward timeout) | DONE (one-cycle completion pulse).
module slc3_mem_seq
  import slc3_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic we_i,
  input  logic ack_i,
  output logic req_o,
  output logic we_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic mdr_cap_o
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  memseq_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             timed_out;

  // TIMEOUT of zero means wait for ack forever
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = REQ;
          cnt_d   = '0;
          we_d    = we_i;
          err_d   = 1'b0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_i) begin
          state_d = DONE;
        end else if (timed_out) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_o     = (state_q == REQ);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign we_o      = we_q;
  assign err_o     = err_q;
  assign mdr_cap_o = (state_q == REQ) && ack_i && !we_q;

endmodule

// File: rtl/slc3_datapath_gen.sv
// SLC-3 datapath: register file, ALU, CC/BEN, PC/IR/MAR/MDR/LED and one shared bus,
// with a self-timed memory sequencer driving the MAR/MDR memory port.
module slc3_datapath_gen
  import slc3_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                LED_W    = 12,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int                TIMEOUT  = 15
) (
  input logic             clk,
  input logic             reset,
  slc3_datapath_gen_if.dp io
);
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] ir_q, pc_q, pc_d, mar_q, mdr_q, mdr_d;
  logic [LED_W-1:0]  led_q;
  logic [2:0]        nzp_q, nzp_d;
  logic              ben_q, bus_err_q;

  logic [DATA_W-1:0] sext5, sext6, sext9, sext11;
  logic [2:0]        dr_idx, sr1_idx;
  logic [DATA_W-1:0] sr1, sr2_op, addr1, addr2, marmux, alu_out, bus;
  logic [3:0]        gates;
  logic              multi_gate, seq_busy, mdr_cap;

  assign sext5  = {{(DATA_W-5){ir_q[4]}},   ir_q[4:0]};
  assign sext6  = {{(DATA_W-6){ir_q[5]}},   ir_q[5:0]};
  assign sext9  = {{(DATA_W-9){ir_q[8]}},   ir_q[8:0]};
  assign sext11 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};

  assign dr_idx  = io.dr_sel  ? ir_q[11:9] : 3'd7;
  assign sr1_idx = io.sr1_sel ? ir_q[8:6]  : ir_q[11:9];
  assign sr1     = regs_q[sr1_idx];
  assign sr2_op  = io.sr2_sel ? regs_q[ir_q[2:0]] : sext5;
  assign addr1   = io.addr1_sel ? pc_q : sr1;
  assign marmux  = addr1 + addr2;

  always_comb begin
    addr2 = '0;
    case (addr2_e'(io.addr2_sel))
      A2_SEXT11: addr2 = sext11;
      A2_SEXT9:  addr2 = sext9;
      A2_SEXT6:  addr2 = sext6;
      default:   addr2 = '0;
    endcase
  end

  always_comb begin
    alu_out = sr1;
    case (aluk_e'(io.aluk))
      ALU_ADD: alu_out = sr1 + sr2_op;
      ALU_AND: alu_out = sr1 & sr2_op;
      ALU_NOT: alu_out = ~sr1;
      default: alu_out = sr1;
    endcase
  end

  // Contention forces the bus to zero rather than OR-ing drivers together
  assign gates      = {io.gate_marmux, io.gate_pc, io.gate_alu, io.gate_mdr};
  assign multi_gate = (gates & (gates - 4'd1)) != 4'd0;

  always_comb begin
    bus = '0;
    case (gates)
      4'b1000: bus = marmux;
      4'b0100: bus = pc_q;
      4'b0010: bus = alu_out;
      4'b0001: bus = mdr_q;
      default: bus = '0;
    endcase
  end

  assign nzp_d = {bus[DATA_W-1], bus == '0, !bus[DATA_W-1] && (bus != '0)};

  always_comb begin
    pc_d = pc_q;
    case (pcmux_e'(io.pc_sel))
      PC_INC:  pc_d = pc_q + DATA_W'(1);
      PC_ADDR: pc_d = marmux;
      PC_BUS:  pc_d = bus;
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    mdr_d = mdr_q;
    if (mdr_cap) begin
      mdr_d = io.mem_rdata;
    end else if (io.ld_mdr && !seq_busy) begin
      mdr_d = io.mio_en ? io.mem_rdata : bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (io.ld_reg) begin
      regs_q[dr_idx] <= bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q      <= '0;
      pc_q      <= PC_RESET;
      mar_q     <= '0;
      mdr_q     <= '0;
      led_q     <= '0;
      nzp_q     <= NZP_RESET;
      ben_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (io.ld_ir)  ir_q  <= bus;
      if (io.ld_pc)  pc_q  <= pc_d;
      if (io.ld_mar && !seq_busy) mar_q <= bus;
      mdr_q <= mdr_d;
      if (io.ld_led) led_q <= ir_q[LED_W-1:0];
      if (io.ld_cc)  nzp_q <= nzp_d;
      if (io.ld_ben) ben_q <= |(ir_q[11:9] & nzp_q);
      bus_err_q <= bus_err_q | multi_gate;
    end
  end

  slc3_mem_seq #(.TIMEOUT(TIMEOUT)) u_mem_seq (
    .clk       (clk),
    .reset     (reset),
    .start_i   (io.mem_start),
    .we_i      (io.mem_we),
    .ack_i     (io.mem_ack),
    .req_o     (io.mem_req),
    .we_o      (io.mem_we_o),
    .busy_o    (seq_busy),
    .done_o    (io.done),
    .err_o     (io.mem_err),
    .mdr_cap_o (mdr_cap)
  );

  assign io.busy      = seq_busy;
  assign io.mem_addr  = mar_q;
  assign io.mem_wdata = mdr_q;
  assign io.ir        = ir_q;
  assign io.pc        = pc_q;
  assign io.mar       = mar_q;
  assign io.mdr       = mdr_q;
  assign io.led       = led_q;
  assign io.nzp       = nzp_q;
  assign io.ben       = ben_q;
  assign io.bus_err   = bus_err_q;

endmodule

// File: tb/tb_slc3_datapath_gen.sv
// Bench for slc3_datapath_gen (32-bit build, TIMEOUT 4): architectural reference model
// for strobe-driven cycles plus directed memory-sequencer scenarios.
module tb_slc3_datapath_gen;
  localparam int              DW     = 32;
  localparam int              LW     = 12;
  localparam logic [DW-1:0]   PC_RST = 32'h0000_3000;
  localparam int              TMO    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slc3_datapath_gen_if #(.DATA_W(DW), .LED_W(LW)) io ();

  slc3_datapath_gen #(.DATA_W(DW), .LED_W(LW), .PC_RESET(PC_RST), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles;
  bit saw_done;

  logic [DW-1:0] m_r [8];
  logic [DW-1:0] m_ir, m_pc, m_mar, m_mdr;
  logic [LW-1:0] m_led;
  logic [2:0]    m_nzp;
  logic          m_ben, m_bus_err;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] sx(input logic [DW-1:0] v, input int bits);
    logic signed [DW-1:0] t;
    t = $signed(v << (DW - bits));
    return t >>> (DW - bits);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_ir = '0; m_pc = PC_RST; m_mar = '0; m_mdr = '0; m_led = '0;
    m_nzp = 3'b010; m_ben = 1'b0; m_bus_err = 1'b0;
  endtask

  task automatic clear_ctrl();
    io.ld_reg = 0; io.ld_ben = 0; io.ld_cc = 0; io.ld_ir = 0;
    io.ld_pc = 0; io.ld_mar = 0; io.ld_mdr = 0; io.ld_led = 0;
    io.gate_marmux = 0; io.gate_pc = 0; io.gate_alu = 0; io.gate_mdr = 0;
    io.dr_sel = 0; io.sr1_sel = 0; io.sr2_sel = 0; io.addr1_sel = 0; io.mio_en = 0;
    io.addr2_sel = 2'd0; io.pc_sel = 2'd0; io.aluk = 2'd0;
    io.mem_start = 0; io.mem_we = 0; io.mem_ack = 0; io.mem_rdata = '0;
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state();
    check_eq("pc",        io.pc,  m_pc);
    check_eq("ir",        io.ir,  m_ir);
    check_eq("mar",       io.mar, m_mar);
    check_eq("mdr",       io.mdr, m_mdr);
    check_eq("led",       DW'(io.led), DW'(m_led));
    check_eq("nzp",       DW'(io.nzp), DW'(m_nzp));
    check_eq("ben",       DW'(io.ben), DW'(m_ben));
    check_eq("bus_err",   DW'(io.bus_err), DW'(m_bus_err));
    check_eq("mem_addr",  io.mem_addr, m_mar);
    check_eq("mem_wdata", io.mem_wdata, m_mdr);
  endtask

  // One idle-sequencer cycle: predict from current strobes, clock, then compare.
  task automatic model_cycle();
    logic [DW-1:0] a, b, a1, a2, alu, bus;
    logic [DW-1:0] r_n [8];
    logic [DW-1:0] ir_n, pc_n, mar_n, mdr_n;
    logic [LW-1:0] led_n;
    logic [2:0]    nzp_n, s1, dr;
    logic          ben_n, berr_n;
    int            ng;
    ng = int'(io.gate_marmux) + int'(io.gate_pc) + int'(io.gate_alu) + int'(io.gate_mdr);
    s1 = io.sr1_sel ? m_ir[8:6] : m_ir[11:9];
    dr = io.dr_sel ? m_ir[11:9] : 3'd7;
    a  = m_r[s1];
    b  = io.sr2_sel ? m_r[m_ir[2:0]] : sx(m_ir, 5);
    a1 = io.addr1_sel ? m_pc : a;
    case (io.addr2_sel)
      2'd0:    a2 = sx(m_ir, 11);
      2'd1:    a2 = sx(m_ir, 9);
      2'd2:    a2 = sx(m_ir, 6);
      default: a2 = '0;
    endcase
    case (io.aluk)
      2'd0:    alu = a + b;
      2'd1:    alu = a & b;
      2'd2:    alu = ~a;
      default: alu = a;
    endcase
    bus = '0;
    if (ng == 1) begin
      if (io.gate_marmux)   bus = a1 + a2;
      else if (io.gate_pc)  bus = m_pc;
      else if (io.gate_alu) bus = alu;
      else                  bus = m_mdr;
    end
    r_n = m_r;
    if (io.ld_reg) r_n[dr] = bus;
    ir_n  = io.ld_ir ? bus : m_ir;
    mar_n = io.ld_mar ? bus : m_mar;
    mdr_n = io.ld_mdr ? (io.mio_en ? io.mem_rdata : bus) : m_mdr;
    led_n = io.ld_led ? m_ir[LW-1:0] : m_led;
    pc_n  = m_pc;
    if (io.ld_pc) begin
      case (io.pc_sel)
        2'd0:    pc_n = m_pc + 1;
        2'd1:    pc_n = a1 + a2;
        2'd2:    pc_n = bus;
        default: pc_n = m_pc;
      endcase
    end
    nzp_n = m_nzp;
    if (io.ld_cc) nzp_n = bus[DW-1] ? 3'b100 : ((bus == 0) ? 3'b010 : 3'b001);
    ben_n  = io.ld_ben ? ((m_ir[11:9] & m_nzp) != 0) : m_ben;
    berr_n = m_bus_err || (ng > 1);
    @(posedge clk);
    m_r = r_n; m_ir = ir_n; m_pc = pc_n; m_mar = mar_n; m_mdr = mdr_n;
    m_led = led_n; m_nzp = nzp_n; m_ben = ben_n; m_bus_err = berr_n;
    @(negedge clk);
    check_state();
  endtask

  task automatic load_ir(input logic [DW-1:0] v);
    clear_ctrl(); io.mem_rdata = v; io.mio_en = 1; io.ld_mdr = 1; model_cycle();
    clear_ctrl(); io.gate_mdr = 1; io.ld_ir = 1; model_cycle();
    clear_ctrl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_ctrl();
    model_reset();
    repeat (3) @(negedge clk);
    check_state();
    check_eq("rst_mem_req",  DW'(io.mem_req),  '0);
    check_eq("rst_mem_we_o", DW'(io.mem_we_o), '0);
    check_eq("rst_busy",     DW'(io.busy),     '0);
    check_eq("rst_done",     DW'(io.done),     '0);
    check_eq("rst_mem_err",  DW'(io.mem_err),  '0);
    reset = 1'b0;
    @(negedge clk);

    io.gate_pc = 1; io.ld_mar = 1; model_cycle(); clear_ctrl();
    check_eq("mar_from_pc", io.mar, PC_RST);
    repeat (3) begin io.ld_pc = 1; io.pc_sel = 2'd0; model_cycle(); end
    clear_ctrl();
    check_eq("pc_inc3", io.pc, PC_RST + 32'd3);

    // R1 = 5, then ADD R2,R1,#-3 with CC and BEN in the same cycle
    load_ir(32'h0000_0200);
    io.mem_rdata = 32'd5; io.mio_en = 1; io.ld_mdr = 1; model_cycle(); clear_ctrl();
    io.gate_mdr = 1; io.ld_reg = 1; io.dr_sel = 1; model_cycle(); clear_ctrl();
    load_ir(32'h0000_147D);
    io.sr1_sel = 1; io.sr2_sel = 0; io.aluk = 2'd0; io.gate_alu = 1;
    io.ld_reg = 1; io.dr_sel = 1; io.ld_cc = 1; io.ld_ben = 1;
    model_cycle(); clear_ctrl();
    check_eq("add_nzp", DW'(io.nzp), DW'(3'b001));
    check_eq("ben_old_nzp", DW'(io.ben), DW'(1'b1));
    io.sr1_sel = 0; io.aluk = 2'd3; io.gate_alu = 1; io.ld_mar = 1; model_cycle(); clear_ctrl();
    check_eq("add_r2", io.mar, 32'd2);
    load_ir(32'h0000_0ABC);
    io.ld_led = 1; model_cycle(); clear_ctrl();
    check_eq("led_load", DW'(io.led), 32'h0000_0ABC);

    for (int i = 0; i < 300; i++) begin
      int g;
      clear_ctrl();
      g = int'($urandom_range(0, 4));
      io.gate_marmux = (g == 1); io.gate_pc = (g == 2);
      io.gate_alu    = (g == 3); io.gate_mdr = (g == 4);
      io.ld_reg = 1'($urandom_range(0, 1)); io.ld_ben = 1'($urandom_range(0, 1));
      io.ld_cc  = 1'($urandom_range(0, 1)); io.ld_pc  = 1'($urandom_range(0, 1));
      io.ld_mar = 1'($urandom_range(0, 1)); io.ld_mdr = 1'($urandom_range(0, 1));
      io.ld_led = 1'($urandom_range(0, 1)); io.ld_ir  = ($urandom_range(0, 3) == 0);
      io.dr_sel = 1'($urandom_range(0, 1)); io.sr1_sel = 1'($urandom_range(0, 1));
      io.sr2_sel = 1'($urandom_range(0, 1)); io.addr1_sel = 1'($urandom_range(0, 1));
      io.mio_en = 1'($urandom_range(0, 1));
      io.addr2_sel = 2'($urandom_range(0, 3)); io.pc_sel = 2'($urandom_range(0, 3));
      io.aluk = 2'($urandom_range(0, 3));
      io.mem_rdata = $urandom; io.mem_ack = 1'($urandom_range(0, 1));
      model_cycle();
    end
    clear_ctrl();

    // Read, ack on the fourth request cycle; MAR/MDR strobes while busy are ignored
    io.mem_we = 0; io.mem_start = 1; clk_cycle(); clear_ctrl();
    check_eq("rd_req",      DW'(io.mem_req),  32'd1);
    check_eq("rd_busy",     DW'(io.busy),     32'd1);
    check_eq("rd_we_o",     DW'(io.mem_we_o), 32'd0);
    check_eq("rd_addr",     io.mem_addr,      m_mar);
    for (int k = 0; k < 3; k++) begin
      io.gate_pc = 1; io.ld_mar = 1; io.ld_mdr = 1;
      clk_cycle(); clear_ctrl();
      check_eq("rd_hold_mar", io.mar, m_mar);
      check_eq("rd_hold_mdr", io.mdr, m_mdr);
      check_eq("rd_req_wait", DW'(io.mem_req), 32'd1);
      check_eq("rd_no_done",  DW'(io.done),    32'd0);
    end
    io.mem_ack = 1; io.mem_rdata = 32'h0000_BEEF;
    clk_cycle(); clear_ctrl();
    m_mdr = 32'h0000_BEEF;
    check_eq("rd_mdr",      io.mdr,          32'h0000_BEEF);
    check_eq("rd_done",     DW'(io.done),    32'd1);
    check_eq("rd_req_drop", DW'(io.mem_req), 32'd0);
    io.gate_pc = 1; io.ld_mar = 1;
    clk_cycle(); clear_ctrl();
    check_eq("rd_done_pulse", DW'(io.done), 32'd0);
    check_eq("rd_idle",       DW'(io.busy), 32'd0);
    check_eq("rd_mar_final",  io.mar,       m_mar);

    // Write with no ack: timeout after TMO+1 request cycles
    io.mem_we = 1; io.mem_start = 1; clk_cycle(); clear_ctrl();
    req_cycles = 0; saw_done = 0;
    for (int k = 0; k < 20 && !saw_done; k++) begin
      if (io.done) saw_done = 1;
      else begin
        if (io.mem_req) req_cycles++;
        if (k == 1) io.mem_start = 1;
        clk_cycle(); clear_ctrl();
      end
    end
    check_eq("to_done_seen", DW'(saw_done),   32'd1);
    check_eq("to_req_cycles", DW'(req_cycles), DW'(TMO + 1));
    check_eq("to_mem_err",   DW'(io.mem_err),  32'd1);
    check_eq("to_we_o",      DW'(io.mem_we_o), 32'd1);
    check_eq("to_mdr_keep",  io.mdr,           m_mdr);
    io.mem_ack = 1; io.mem_rdata = 32'h0000_DEAD;
    clk_cycle(); clear_ctrl();
    check_eq("to_idle",       DW'(io.busy),    32'd0);
    check_eq("to_ack_ignored", io.mdr,         m_mdr);
    check_eq("to_err_sticky", DW'(io.mem_err), 32'd1);

    // Next read clears mem_err and completes at minimum latency
    io.mem_we = 0; io.mem_start = 1; clk_cycle();
    check_eq("rd2_err_clr", DW'(io.mem_err), 32'd0);
    check_eq("rd2_req",     DW'(io.mem_req), 32'd1);
    io.mem_start = 0; io.mem_ack = 1; io.mem_rdata = 32'h1234_5678;
    clk_cycle(); clear_ctrl();
    m_mdr = 32'h1234_5678;
    check_eq("rd2_done", DW'(io.done), 32'd1);
    check_eq("rd2_mdr",  io.mdr,       32'h1234_5678);
    clk_cycle();
    check_eq("rd2_idle", DW'(io.busy), 32'd0);
    model_cycle();

    // Bus contention
    io.gate_pc = 1; io.gate_alu = 1; io.ld_mar = 1; model_cycle(); clear_ctrl();
    check_eq("cont_bus_zero", io.mar,             32'd0);
    check_eq("cont_bus_err",  DW'(io.bus_err),    32'd1);
    io.gate_pc = 1; io.ld_mar = 1; model_cycle(); clear_ctrl();
    check_eq("cont_err_sticky", DW'(io.bus_err),  32'd1);

    // Reset in the middle of a request
    io.mem_start = 1; clk_cycle(); clear_ctrl();
    check_eq("rstreq_req", DW'(io.mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rstreq_drop", DW'(io.mem_req), 32'd0);
    check_eq("rstreq_busy", DW'(io.busy),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_state();
    clk_cycle();
    check_eq("rstreq_stay_idle", DW'(io.busy), 32'd0);

    // PC wrap at full width
    io.mem_rdata = 32'hFFFF_FFFF; io.mio_en = 1; io.ld_mdr = 1; model_cycle(); clear_ctrl();
    io.gate_mdr = 1; io.pc_sel = 2'd2; io.ld_pc = 1; model_cycle(); clear_ctrl();
    check_eq("pc_max", io.pc, 32'hFFFF_FFFF);
    io.pc_sel = 2'd0; io.ld_pc = 1; model_cycle(); clear_ctrl();
    check_eq("pc_wrap", io.pc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
